// File: rtl/dist_line_mover.sv
// Purpose: moves runs of whole 256-bit lines between data memory and a 32-bit valid/ready word stream.
// Latency: store = 8 accepted words + 1 strobe cycle (+ busy stall); load = strobe + capture (+ busy stall) then 8 transfers.
// Backpressure: s_in_ready is high only while filling; s_out holds its data until s_out_ready; strobes wait out mem_busy.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   cmd_valid/ready/dir/block/count, done   command handshake and completion pulse
//   mem_busy                CPU port active; no line strobe is issued while high
//   dmem_addr/read/write/wdata/rdata        256-bit line port into data memory
//   s_in_valid/ready/data   store-direction words (stream -> memory)
//   s_out_valid/ready/data  load-direction words (memory -> stream)
module dist_line_mover #(
  parameter int BLOCK_BITS = 7,
  parameter int WORDS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [BLOCK_BITS-1:0] cmd_block,
  input  logic [7:0]            cmd_count,
  output logic                  done,
  input  logic                  mem_busy,
  output logic [31:0]           dmem_addr,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [32*WORDS-1:0]   dmem_wdata,
  input  logic [32*WORDS-1:0]   dmem_rdata,
  input  logic                  s_in_valid,
  output logic                  s_in_ready,
  input  logic [31:0]           s_in_data,
  output logic                  s_out_valid,
  input  logic                  s_out_ready,
  output logic [31:0]           s_out_data
);

  localparam int LINE_BITS = 32 * WORDS;
  localparam int WB        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WB-1:0] LAST_W = WB'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, WREQ, RREQ, RWAIT, DRAIN, FIN
  } state_t;

  state_t                state;
  logic [BLOCK_BITS-1:0] line_idx;
  logic [7:0]            remaining;
  logic [WB-1:0]         w;
  logic [LINE_BITS-1:0]  line_buf;

  // Byte address of a line: index in [BLOCK_BITS+4:5], everything else zero.
  function automatic logic [31:0] line_addr(input logic [BLOCK_BITS-1:0] idx);
    logic [31:0] a;
    a = '0;
    a[BLOCK_BITS+4:5] = idx;
    return a;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      line_idx    <= '0;
      remaining   <= '0;
      w           <= '0;
      line_buf    <= '0;
      cmd_ready   <= 1'b1;
      done        <= 1'b0;
      dmem_addr   <= '0;
      dmem_read   <= 1'b0;
      dmem_write  <= 1'b0;
      dmem_wdata  <= '0;
      s_in_ready  <= 1'b0;
      s_out_valid <= 1'b0;
      s_out_data  <= '0;
    end else begin
      // Strobes and done are single-cycle pulses.
      done       <= 1'b0;
      dmem_read  <= 1'b0;
      dmem_write <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            line_idx  <= cmd_block;
            remaining <= cmd_count;
            w         <= '0;
            cmd_ready <= 1'b0;
            if (cmd_count == 8'd0) begin
              state <= FIN;
            end else if (cmd_dir) begin
              state      <= FILL;
              s_in_ready <= 1'b1;
            end else begin
              state <= RREQ;
            end
          end
        end

        FILL: begin
          if (s_in_valid && s_in_ready) begin
            line_buf[32*int'(w) +: 32] <= s_in_data;
            if (w == LAST_W) begin
              w          <= '0;
              s_in_ready <= 1'b0;
              state      <= WREQ;
            end else begin
              w <= w + 1'b1;
            end
          end
        end

        WREQ: begin
          if (!mem_busy) begin
            dmem_write <= 1'b1;
            dmem_addr  <= line_addr(line_idx);
            dmem_wdata <= line_buf;
            line_idx   <= line_idx + 1'b1;   // wraps modulo 2^BLOCK_BITS
            remaining  <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              state <= FIN;
            end else begin
              state      <= FILL;
              w          <= '0;
              s_in_ready <= 1'b1;
            end
          end
        end

        RREQ: begin
          if (!mem_busy) begin
            dmem_read <= 1'b1;
            dmem_addr <= line_addr(line_idx);
            state     <= RWAIT;
          end
        end

        RWAIT: begin
          // First RWAIT cycle is the strobe cycle itself; memory returns the
          // line one cycle later, so capture only once the strobe has dropped.
          if (!dmem_read) begin
            line_buf    <= dmem_rdata;
            s_out_data  <= dmem_rdata[31:0];
            s_out_valid <= 1'b1;
            w           <= '0;
            state       <= DRAIN;
          end
        end

        DRAIN: begin
          if (s_out_valid && s_out_ready) begin
            if (w == LAST_W) begin
              w           <= '0;
              s_out_valid <= 1'b0;
              line_idx    <= line_idx + 1'b1;
              remaining   <= remaining - 8'd1;
              state       <= (remaining == 8'd1) ? FIN : RREQ;
            end else begin
              w          <= w + 1'b1;
              s_out_data <= line_buf[32*(int'(w)+1) +: 32];
            end
          end
        end

        FIN: begin
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dist_line_mover.sv
// Directed bench for dist_line_mover with a line-memory model on the dmem port.
module tb_dist_line_mover;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready, cmd_dir, done, mem_busy;
  logic [6:0]   cmd_block;
  logic [7:0]   cmd_count;
  logic [31:0]  dmem_addr;
  logic         dmem_read, dmem_write;
  logic [255:0] dmem_wdata;
  logic [255:0] dmem_rdata = '0;
  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0]  s_in_data, s_out_data;

  always #5 clk = ~clk;

  dist_line_mover dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_block(cmd_block), .cmd_count(cmd_count), .done(done),
    .mem_busy(mem_busy),
    .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .s_in_valid(s_in_valid), .s_in_ready(s_in_ready), .s_in_data(s_in_data),
    .s_out_valid(s_out_valid), .s_out_ready(s_out_ready), .s_out_data(s_out_data)
  );

  // Memory model and protocol monitor.
  logic [255:0] mem [0:127];
  logic         pre_we = 1'b0;
  logic [6:0]   pre_idx = '0;
  logic [255:0] pre_dat = '0;
  logic         busy_q = 1'b0;
  int           viol = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  logic [31:0]  rd_addr_q [$];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    if (dmem_write) mem[dmem_addr[11:5]] <= dmem_wdata;
    if (dmem_read) dmem_rdata <= mem[dmem_addr[11:5]];
    if (((dmem_read || dmem_write) && busy_q) || (dmem_read && dmem_write)) viol <= viol + 1;
    busy_q <= mem_busy;
    if (dmem_write) wr_cnt <= wr_cnt + 1;
    if (dmem_read) begin
      rd_cnt <= rd_cnt + 1;
      rd_addr_q.push_back(dmem_addr);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic dir, input logic [6:0] blk, input logic [7:0] cnt);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_block = blk; cmd_count = cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    s_in_valid = 1'b1;
    s_in_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (s_in_ready) break;
      @(negedge clk);
    end
    chk("s_in_ready_seen", 256'(s_in_ready), 256'(1));
    @(negedge clk);
  endtask

  task automatic wait_write(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (dmem_write) break;
      @(negedge clk);
    end
    chk(tag, 256'(dmem_write), 256'(1));
  endtask

  logic [255:0] exp_line, line_a, line_b;
  logic [31:0]  outq [$];
  logic [31:0]  prev_dat;
  logic         prev_stall, got_done;
  int           stab_bad, w0, r0, d0;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_block = '0; cmd_count = '0;
    mem_busy = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cmd_ready", 256'(cmd_ready), 256'(1));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_strobes", 256'({dmem_read, dmem_write}), 256'(0));
    chk("rst_addr", 256'(dmem_addr), 256'(0));
    chk("rst_wdata", dmem_wdata, 256'(0));
    chk("rst_stream", 256'({s_in_ready, s_out_valid}), 256'(0));
    chk("rst_s_out_data", 256'(s_out_data), 256'(0));
    reset = 1'b0;
    @(negedge clk);

    // Store one line at block 5, words 0x11..0x88 back-to-back
    do_cmd(1'b1, 7'd5, 8'd1);
    chk("st1_cmd_ready_low", 256'(cmd_ready), 256'(0));
    for (int k = 0; k < 8; k++) begin
      exp_line[32*k +: 32] = 32'h11 * (k + 1);
      send_word(32'h11 * (k + 1));
    end
    s_in_valid = 1'b0;
    chk("st1_s_in_ready_drop", 256'(s_in_ready), 256'(0));
    wait_write("st1_write_seen");
    chk("st1_addr", 256'(dmem_addr), 256'(32'h0000_00A0));
    chk("st1_wdata", dmem_wdata, exp_line);
    @(negedge clk);
    chk("st1_done", 256'(done), 256'(1));
    chk("st1_write_single", 256'(dmem_write), 256'(0));
    @(negedge clk);
    chk("st1_done_pulse", 256'(done), 256'(0));
    chk("st1_wr_cnt", 256'(wr_cnt), 256'(1));

    // Busy arbitration: mem_busy held at WREQ, store at block 10
    mem_busy = 1'b1;
    do_cmd(1'b1, 7'd10, 8'd1);
    for (int k = 0; k < 8; k++) begin
      exp_line[32*k +: 32] = 32'h100 + k;
      send_word(32'h100 + k);
    end
    s_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("busy_no_write", 256'(dmem_write), 256'(0));
      @(negedge clk);
    end
    mem_busy = 1'b0;
    @(negedge clk);
    chk("busy_write_after_fall", 256'(dmem_write), 256'(1));
    chk("busy_addr", 256'(dmem_addr), 256'(32'h0000_0140));
    chk("busy_wdata", dmem_wdata, exp_line);
    @(negedge clk);
    chk("busy_write_once", 256'(dmem_write), 256'(0));
    @(negedge clk);
    chk("busy_wr_cnt", 256'(wr_cnt), 256'(2));

    // Load two lines with index wrap 127 -> 0, s_out_ready toggling
    for (int k = 0; k < 8; k++) begin
      line_a[32*k +: 32] = 32'hA000_0000 + k;
      line_b[32*k +: 32] = 32'hB000_0000 + k;
    end
    pre_we = 1'b1; pre_idx = 7'd127; pre_dat = line_a;
    @(negedge clk);
    pre_idx = 7'd0; pre_dat = line_b;
    @(negedge clk);
    pre_we = 1'b0;
    rd_addr_q.delete();
    d0 = done_cnt;
    do_cmd(1'b0, 7'd127, 8'd2);
    prev_stall = 1'b0; prev_dat = '0; got_done = 1'b0; stab_bad = 0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
      if (prev_stall && (!s_out_valid || s_out_data !== prev_dat)) stab_bad++;
      s_out_ready = ~s_out_ready;
      prev_stall  = s_out_valid && !s_out_ready;
      prev_dat    = s_out_data;
      if (s_out_valid && s_out_ready) outq.push_back(s_out_data);
    end
    s_out_ready = 1'b0;
    chk("ld_done_seen", 256'(got_done), 256'(1));
    repeat (3) @(negedge clk);
    chk("ld_done_once", 256'(done_cnt - d0), 256'(1));
    chk("ld_word_count", 256'(outq.size()), 256'(16));
    for (int k = 0; k < 16 && k < outq.size(); k++)
      chk("ld_word", 256'(outq[k]), 256'(k < 8 ? (32'hA000_0000 + k) : (32'hB000_0000 + k - 8)));
    chk("ld_stable", 256'(stab_bad), 256'(0));
    chk("ld_rd_count", 256'(rd_addr_q.size()), 256'(2));
    if (rd_addr_q.size() == 2) begin
      chk("ld_addr0", 256'(rd_addr_q[0]), 256'(32'h0000_0FE0));
      chk("ld_addr1", 256'(rd_addr_q[1]), 256'(32'h0000_0000));
    end

    // count = 0: no strobes, done two cycles after the handshake
    w0 = wr_cnt; r0 = rd_cnt;
    do_cmd(1'b1, 7'd3, 8'd0);
    chk("z_done_early", 256'(done), 256'(0));
    @(negedge clk);
    chk("z_done", 256'(done), 256'(1));
    @(negedge clk);
    chk("z_done_drop", 256'(done), 256'(0));
    chk("z_cmd_ready", 256'(cmd_ready), 256'(1));
    chk("z_no_strobes", 256'((wr_cnt - w0) + (rd_cnt - r0)), 256'(0));

    // Reset after four of eight store words
    w0 = wr_cnt; d0 = done_cnt;
    do_cmd(1'b1, 7'd20, 8'd1);
    for (int k = 0; k < 4; k++) send_word(32'hDEAD_0000 + k);
    s_in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_cmd_ready", 256'(cmd_ready), 256'(1));
    chk("rst_mid_s_in_ready", 256'(s_in_ready), 256'(0));
    repeat (4) @(negedge clk);
    chk("rst_mid_no_write", 256'(wr_cnt - w0), 256'(0));
    chk("rst_mid_no_done", 256'(done_cnt - d0), 256'(0));
    do_cmd(1'b1, 7'd20, 8'd1);
    for (int k = 0; k < 8; k++) begin
      exp_line[32*k +: 32] = 32'h5000 + k;
      send_word(32'h5000 + k);
    end
    s_in_valid = 1'b0;
    wait_write("rst_new_write_seen");
    chk("rst_new_addr", 256'(dmem_addr), 256'(32'h0000_0280));
    chk("rst_new_wdata", dmem_wdata, exp_line);
    @(negedge clk);
    chk("rst_new_done", 256'(done), 256'(1));

    repeat (2) @(negedge clk);
    chk("protocol_violations", 256'(viol), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dist_line_mover.md
Name: dist_line_mover

Overview:
- Initiator for the data memory's 256-bit line-distribution port: drives the line address, the line read/write strobes and the 256-bit line data, and captures returned lines.
- Moves a run of whole cache lines in either direction, one line at a time, between data memory and a 32-bit valid/ready word stream.
- Store: packs 8 stream words into a line and writes it. Load: reads a line and emits its 8 words.
- Sits beside the CPU data path and issues a line access only in a cycle where the memory reports not busy.

Parameters:
- BLOCK_BITS, 7, line-index width; the line index occupies address bits [BLOCK_BITS+4:5].
- WORDS, 8, 32-bit words per line; the line width is 32*WORDS (256).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offer.
- cmd_ready  out  1  high only in IDLE.
- cmd_dir  in  1  0 = load (memory to s_out), 1 = store (s_in to memory).
- cmd_block  in  BLOCK_BITS  first line index.
- cmd_count  in  8  number of lines, 0..255.
- done  out  1  one-cycle pulse when a command completes.
- mem_busy  in  1  high while the CPU port is active (stall, memread or memwrite); no strobe may be issued while it is high.
- dmem_addr  out  32  {zeros, line index, 5'b0}.
- dmem_read  out  1  line-read strobe, one cycle.
- dmem_write  out  1  line-write strobe, one cycle.
- dmem_wdata  out  256  line to write; word k is bits [32k+31:32k].
- dmem_rdata  in  256  registered line data, valid on the cycle after dmem_read.
- s_in_valid  in  1  store-direction word offer.
- s_in_ready  out  1  store-direction word accept.
- s_in_data  in  32  store-direction word.
- s_out_valid  out  1  load-direction word offer.
- s_out_ready  in  1  load-direction word accept.
- s_out_data  out  32  load-direction word.

Behaviour:
- Reset values: cmd_ready=1, done=0, dmem_read=0, dmem_write=0, dmem_addr=0, dmem_wdata=0, s_in_ready=0, s_out_valid=0, s_out_data=0; state=IDLE.
- All outputs are registered.
- States: IDLE, FILL, WREQ, RREQ, RWAIT, DRAIN, FIN.
- IDLE, cmd_valid=1:
  - latch dir, block, count, and clear word index w.
  - count=0 -> FIN.
  - otherwise dir=1 -> FILL; dir=0 -> RREQ.
- FILL:
  - s_in_ready=1; each s_in_valid&s_in_ready writes s_in_data into word w of the line buffer and increments w.
  - After word 7 is accepted, s_in_ready drops the next cycle; go to WREQ.
- WREQ:
  - Wait while mem_busy=1.
  - In the first cycle with mem_busy=0, drive dmem_write=1 for exactly one cycle with dmem_addr=current line and dmem_wdata=buffer.
  - Then decrement remaining and increment the line index modulo 2^BLOCK_BITS (127 wraps to 0).
  - remaining=0 -> FIN, else FILL with w=0.
- RREQ:
  - Wait while mem_busy=1, then pulse dmem_read for one cycle with dmem_addr=current line.
  - Next state RWAIT.
- RWAIT: capture dmem_rdata into the buffer (exactly one cycle), go to DRAIN.
- DRAIN:
  - s_out_valid=1 with s_out_data = word w.
  - Advance w only on s_out_valid&s_out_ready; hold data stable while ready=0.
  - After word 7 transfers: advance the line as in WREQ; remaining=0 -> FIN, else RREQ.
- FIN: done=1 for one cycle, go to IDLE.
- dmem_addr and dmem_wdata hold their last values outside strobe cycles.
- Never assert dmem_read and dmem_write together; never strobe while mem_busy=1.
- Latency:
  - store, per line: 8 accepted words + 1 + stall cycles.
  - load, per line: 1 strobe + 1 capture + stall cycles, then 8 transfers.
- Reset mid-operation: return to IDLE immediately, drop outstanding strobes. A partially filled line is never written. Lines already written stay written. No done pulse.
- A cmd_valid arriving while not IDLE is ignored (cmd_ready=0).

Test Plan:
- Store 1 line: block=5, count=1, s_in words 0x11..0x88 back-to-back -> one dmem_write with dmem_addr=0x000000A0, dmem_wdata word0=0x11 ... word7=0x88; done 1 cycle later.
- Load 2 lines with wrap: block=127, count=2, memory line127=A, line0=B -> dmem_read at addr 0xFE0 then 0x000; s_out carries A words 0..7 then B words 0..7; done once.
- Backpressure: during a load, toggle s_out_ready 1/0 each cycle -> 8 words, none dropped or duplicated, s_out_data stable while ready=0.
- Busy arbitration: hold mem_busy=1 for 5 cycles at WREQ -> no dmem_write during those cycles; single dmem_write in the cycle after mem_busy falls.
- count=0 -> no strobes; done pulses 2 cycles after the command handshake.
- Reset after 4 of 8 store words -> no dmem_write; cmd_ready=1 the next cycle; a new store command completes normally.
